// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Single-port 32-bit data memory behind a valid/ready request and
//            response handshake. Each request is accepted in IDLE, then
//            WAIT_CYCLES wait states follow, and the response is held in RESP
//            until the initiator takes it. Stores are byte-lane masked. Loads
//            return the whole addressed word.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready, req_we, req_addr[31:0], req_wdata[31:0],
//            req_be[3:0]                      -- request channel
//            rsp_valid/rsp_ready, rsp_rdata[31:0], rsp_err -- response channel
// Options  : DMEM_ERR_CHECK_EN -- when defined, misaligned or out-of-range
//            accesses respond with rsp_err=1 and leave memory untouched.
//            When undefined, the low address bits are ignored and the word
//            index wraps modulo DEPTH_WORDS.
// Revision : 1.0 -- initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Request fields used for the access. With zero wait states the access
  // happens on the accept edge itself, so the fields being latched on that
  // edge are used directly; otherwise the latched copies are used.
  logic             in_idle;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_bad;
  logic             enter_resp;
  logic             mem_we;
  logic [31:0]      cur_word;
  logic [31:0]      wr_word;

  assign in_idle   = (state_q == S_IDLE);
  assign acc_we    = in_idle ? req_we    : we_q;
  assign acc_addr  = in_idle ? req_addr  : addr_q;
  assign acc_wdata = in_idle ? req_wdata : wdata_q;
  assign acc_be    = in_idle ? req_be    : be_q;
  assign acc_idx   = acc_addr[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
  assign acc_bad = (acc_addr[1:0] != 2'b00) ||
                   (acc_addr[31:2] >= 30'(DEPTH_WORDS));
`else
  // Upper index bits and byte offset are intentionally discarded (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:IDX_W+2], acc_addr[1:0]};
  assign acc_bad = 1'b0;
`endif

  // The edge that moves the FSM into RESP is the single point of access.
  assign enter_resp = (in_idle && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd0));

  // Reset gating keeps a request caught by reset from touching storage.
  assign mem_we = enter_resp && acc_we && !acc_bad && !rst;

  assign cur_word = mem[acc_idx];

  always_comb begin
    wr_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (acc_be[i]) begin
        wr_word[8*i +: 8] = acc_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response payload is captured once and then held through RESP.
    if (enter_resp) begin
      rdata_d = (!acc_we && !acc_bad) ? cur_word : 32'd0;
      err_d   = acc_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= wr_word;
    end
  end

  assign req_ready = in_idle;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder. Instantiates the
//            default configuration (256 words, 2 wait states) plus a
//            zero-wait-state instance for back-to-back throughput. Expected
//            responses come from a word-array model of the memory.
//            Honours DMEM_ERR_CHECK_EN the same way the design does.
// Revision : 1.0 -- initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int TB_DEPTH = 256;
  localparam int TB_WAIT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        d0_req_valid = 1'b0;
  logic        d0_req_ready;
  logic        d0_req_we = 1'b0;
  logic [31:0] d0_req_addr = 32'd0;
  logic [31:0] d0_req_wdata = 32'd0;
  logic [3:0]  d0_req_be = 4'd0;
  logic        d0_rsp_valid;
  logic        d0_rsp_ready = 1'b0;
  logic [31:0] d0_rsp_rdata;
  logic        d0_rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [TB_DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS(TB_DEPTH),
    .WAIT_CYCLES(TB_WAIT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  data_mem_responder #(
    .DEPTH_WORDS(16),
    .WAIT_CYCLES(0)
  ) u_dut_w0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (d0_req_valid),
    .req_ready (d0_req_ready),
    .req_we    (d0_req_we),
    .req_addr  (d0_req_addr),
    .req_wdata (d0_req_wdata),
    .req_be    (d0_req_be),
    .rsp_valid (d0_rsp_valid),
    .rsp_ready (d0_rsp_ready),
    .rsp_rdata (d0_rsp_rdata),
    .rsp_err   (d0_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // An access is rejected when misaligned or beyond the storage size.
  function automatic bit model_bad(input logic [31:0] addr);
`ifdef DMEM_ERR_CHECK_EN
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= TB_DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] addr);
    return int'((addr >> 2) % TB_DEPTH);
  endfunction

  // One complete transaction: issue, check latency and response, optionally
  // stall the response for `hold` cycles, then retire it.
  task automatic run_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int hold);
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
    logic        exp_err;
    logic [31:0] held_rdata;
    logic        held_err;
    int          guard;
    int          k;

    exp_err   = model_bad(addr);
    exp_rdata = 32'd0;
    exp_word  = 32'd0;
    if (!exp_err) begin
      exp_word = model_mem[model_idx(addr)];
      if (!we) begin
        exp_rdata = exp_word;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) exp_word[8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {31'd0, req_ready}, 32'd1);

    @(negedge clk);
    // Scramble the request bus after accept; the pending access must not care.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);

    k = 0;
    while (!rsp_valid && k < 40) begin
      check("busy_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(TB_WAIT));
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    held_rdata = rsp_rdata;
    held_err   = rsp_err;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, held_rdata);
      check("hold_err", {31'd0, rsp_err}, {31'd0, held_err});
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("retire_ready", {31'd0, req_ready}, 32'd1);
    check("retire_valid", {31'd0, rsp_valid}, 32'd0);

    if (we && !exp_err) model_mem[model_idx(addr)] = exp_word;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    // Zero-wait-state instance: back-to-back requests every 2 cycles
    d0_rsp_ready = 1'b1;
    d0_req_valid = 1'b1;
    d0_req_addr  = 32'h8;
    for (int n = 0; n < 12; n++) begin
      check("w0_req_ready", {31'd0, d0_req_ready}, 32'((n % 2) == 0));
      check("w0_rsp_valid", {31'd0, d0_rsp_valid}, 32'((n % 2) == 1));
      @(negedge clk);
    end
    d0_req_valid = 1'b0;
    d0_rsp_ready = 1'b0;

    // Known storage contents
    for (int i = 0; i < TB_DEPTH; i++) begin
      run_req(1'b1, 32'(i * 4), 32'd0, 4'hF, 0);
    end

    // Full-word store and reload, then a single-lane store
    run_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    run_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
    check("word_0x10", model_mem[4], 32'hDEADBEEF);
    run_req(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
    run_req(1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Byte-enable of zero is a no-op store
    run_req(1'b1, 32'h10, 32'h11223344, 4'h0, 0);
    run_req(1'b0, 32'h10, 32'h0, 4'hF, 0);

    // Response back-pressure
    run_req(1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Misaligned / out-of-range handling (error or wrap-around)
    run_req(1'b1, 32'h400, 32'h5, 4'hF, 0);
    run_req(1'b0, 32'h0, 32'h0, 4'h0, 0);
    run_req(1'b0, 32'h11, 32'h0, 4'h0, 0);

    // Reset while a store is waiting
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rstw_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstw_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("rstw_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    run_req(1'b0, 32'h20, 32'h0, 4'h0, 0);
    check("rstw_mem", model_mem[8], 32'd0);

    // Randomized traffic, biased toward a small address window for reuse
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0:       a = $urandom;
        1:       a = {22'd0, 8'($urandom), 2'($urandom)};
        default: a = {26'd0, 4'($urandom), 2'b00};
      endcase
      run_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001: Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit storage words (power of two, 4..4096).
REQ-002: Parameter WAIT_CYCLES, default 2, SHALL set the wait states inserted between request accept and response (0..15).
REQ-003: clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004: rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005: req_valid  input  1  SHALL flag a valid initiator request.
REQ-006: req_ready  output  1  SHALL flag that the responder accepts a request this cycle.
REQ-007: req_we  input  1  SHALL select store (1) or load (0).
REQ-008: req_addr  input  32  SHALL give the byte address.
REQ-009: req_wdata  input  32  SHALL give the store data.
REQ-010: req_be  input  4  SHALL give per-byte store enables; bit i enables byte lane i, bits [8i+7:8i].
REQ-011: rsp_valid  output  1  SHALL flag a valid response.
REQ-012: rsp_ready  input  1  SHALL flag that the initiator takes the response this cycle.
REQ-013: rsp_rdata  output  32  SHALL carry load data; 0 for stores and errors.
REQ-014: rsp_err  output  1  SHALL flag a failed access.

Function
REQ-015: FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016: Accept SHALL occur on a cycle with req_valid=1 in IDLE; req_we, req_addr, req_wdata, req_be SHALL be latched on that edge.
REQ-017: On accept, WAIT_CYCLES=0 SHALL go to RESP; otherwise go to WAIT with a down-counter loaded with WAIT_CYCLES-1.
REQ-018: WAIT SHALL decrement the counter each cycle and go to RESP when it is 0.
REQ-019: rsp_valid SHALL assert exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020: The memory access SHALL be performed once, on the edge entering RESP, using only latched request fields.
REQ-021: A store SHALL write only the lanes enabled by the latched req_be; req_be=0 SHALL be a legal no-op store with rsp_err=0.
REQ-022: A load SHALL return the full addressed word on rsp_rdata, ignoring req_be.
REQ-023: In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1.
REQ-024: When rsp_valid=1 and rsp_ready=1, the FSM SHALL return to IDLE on that edge; no request is accepted on that same edge.
REQ-025: Peak throughput SHALL be one request per WAIT_CYCLES+2 cycles.
REQ-026: Changes to req_* inputs after accept SHALL have no effect on the pending access.
REQ-027: A load issued after a store to the same word SHALL return the stored data.

Reset
REQ-028: Asserting rst SHALL force state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready SHALL read 1 one cycle after rst deasserts.
REQ-029: rst asserted during WAIT SHALL drop the pending request; a pending store SHALL NOT modify memory.
REQ-030: Storage contents SHALL NOT be reset.

Configuration
REQ-031: With DMEM_ERR_CHECK_EN defined, an access where req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS SHALL respond with rsp_err=1 and rsp_rdata=0, and SHALL leave memory unmodified.
REQ-032: Without DMEM_ERR_CHECK_EN, rsp_err SHALL be tied 0, req_addr[1:0] SHALL be ignored, and the word index SHALL be req_addr[31:2] modulo DEPTH_WORDS (wrap-around).

Verification
REQ-033: Store 0xDEADBEEF to 0x10 with be=4'hF, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid rises 3 cycles after each accept (WAIT_CYCLES=2).
REQ-034: After REQ-033, store 0x000000AA to 0x10 with be=4'b0001, then load 0x10 -> 0xDEADBEAA.
REQ-035: Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; IDLE entered the cycle after rsp_ready=1.
REQ-036: With DMEM_ERR_CHECK_EN, load 0x11 and store to 0x400 (DEPTH_WORDS=256) -> both give rsp_err=1, rsp_rdata=0, memory unchanged. Without it, storing 0x5 to 0x400 and then loading 0x0 -> 0x00000005.
REQ-037: Assert rst one cycle after accepting a store of 0x12345678 to 0x20 (old content 0) -> rsp_valid never asserts; a later load of 0x20 returns 0.
REQ-038: With WAIT_CYCLES=0, hold req_valid=1 with rsp_ready=1 -> accepts occur every 2 cycles and rsp_valid follows each accept by 1 cycle.
